// File: rtl/cts_pkg.sv
// Shared types and helpers for the counter-stream checker.
// Holds the checker FSM states, parameter defaults and a saturating increment.
package cts_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } cts_state_e;

    localparam int unsigned CTS_W_DEF   = 2;
    localparam int unsigned CTS_LAT_DEF = 1;
    localparam int unsigned CTS_ECW_DEF = 8;

    // Holds at vmax instead of wrapping; callers narrow the result to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
        return (v >= vmax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cts_dly_line.sv
// 1-bit shift register of depth DEPTH with synchronous active-low clear.
// o_q is the input delayed DEPTH cycles, o_pre the input delayed DEPTH-1 cycles.
module cts_dly_line #(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_pre
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) r_sr <= '0;
                else          r_sr <= i_d;
            end
            assign o_pre = i_d;
        end else begin : g_multi
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) r_sr <= '0;
                else          r_sr <= {r_sr[DEPTH-2:0], i_d};
            end
            assign o_pre = r_sr[DEPTH-2];
        end
    endgenerate

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/cnt_stream_checker.sv
// Sink-side integrity monitor for the enable-driven counter stream.
// Rebuilds the expected count from the delayed enable, locks on, then flags and counts mismatches.
module cnt_stream_checker
    import cts_pkg::*;
#(
    parameter int unsigned W        = CTS_W_DEF,
    parameter int unsigned LAT      = CTS_LAT_DEF,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned MISS_MAX = 3,
    parameter int unsigned ECW      = CTS_ECW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           on_i,
    input  logic [W-1:0]   cnt_i,
    output logic           locked_o,
    output logic           err_o,
    output logic [ECW-1:0] err_cnt_o,
    output logic [W-1:0]   exp_o
);

    localparam logic [ECW-1:0] ERR_MAX = '1;

    cts_state_e     r_state;
    logic [2:0]     r_fill;
    logic [3:0]     r_match;
    logic [3:0]     r_miss;
    logic [W-1:0]   r_prev;
    logic [W-1:0]   r_exp;
    logic           r_locked;
    logic           r_err;
    logic [ECW-1:0] r_err_cnt;

    logic           w_on_d;
    logic           w_on_nxt;
    logic [W-1:0]   w_pred;
    logic           w_acq_hit;
    logic           w_lock_miss;

    // w_on_d is the enable behind the current sample's step; w_on_nxt steps the next one.
    cts_dly_line #(
        .DEPTH (LAT + 1)
    ) u_dly (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (on_i),
        .o_q     (w_on_d),
        .o_pre   (w_on_nxt)
    );

    assign w_pred      = r_prev + W'(w_on_d);
    assign w_acq_hit   = (cnt_i == w_pred);
    assign w_lock_miss = (cnt_i != r_exp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_fill    <= '0;
            r_match   <= '0;
            r_miss    <= '0;
            r_prev    <= '0;
            r_exp     <= '0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                FILL: begin
                    r_prev <= cnt_i;
                    if (r_fill == 3'(LAT)) begin
                        r_fill  <= '0;
                        r_match <= '0;
                        r_state <= ACQ;
                    end else begin
                        r_fill <= r_fill + 3'd1;
                    end
                end
                ACQ: begin
                    r_prev <= cnt_i;
                    if (w_acq_hit) begin
                        if (r_match == 4'(LOCK_CNT - 1)) begin
                            r_match  <= '0;
                            r_miss   <= '0;
                            r_exp    <= cnt_i + W'(w_on_nxt);
                            r_locked <= 1'b1;
                            r_state  <= LOCKED;
                        end else begin
                            r_match <= r_match + 4'd1;
                        end
                    end else begin
                        r_match <= '0;
                    end
                end
                LOCKED: begin
                    // Model free-runs; a bad sample never re-seeds it.
                    r_exp <= r_exp + W'(w_on_nxt);
                    if (w_lock_miss) begin
                        r_err     <= 1'b1;
                        r_err_cnt <= ECW'(sat_inc(32'(r_err_cnt), 32'(ERR_MAX)));
                        if (r_miss == 4'(MISS_MAX - 1)) begin
                            r_miss   <= '0;
                            r_match  <= '0;
                            r_prev   <= cnt_i;
                            r_locked <= 1'b0;
                            r_state  <= ACQ;
                        end else begin
                            r_miss <= r_miss + 4'd1;
                        end
                    end else begin
                        r_miss <= '0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign locked_o  = r_locked;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
    assign exp_o     = r_exp;

endmodule

// File: tb/tb_cnt_stream_checker.sv
// Scoreboard bench for cnt_stream_checker: three instances (LAT=1, LAT=0, LAT=3/ECW=2)
// fed by local generator models; expected err/lock events are queued and popped by a monitor.
module tb_cnt_stream_checker;

    localparam int LAT_A = 1;
    localparam int LAT_B = 0;
    localparam int LAT_C = 3;
    localparam int LOCK  = 4;
    localparam int EV_ERR = 0;
    localparam int EV_UP  = 1;
    localparam int EV_DN  = 2;

    typedef struct {
        int inst;
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a = 1'b0, rst_bc = 1'b0;
    logic       on_a = 1'b0, on_b = 1'b0, on_c = 1'b0;
    logic [1:0] cor_a = 2'd0, cor_c = 2'd0;

    // Generator models: count register followed by LAT plain flop stages.
    logic [1:0] ga, pa, gb, gc, pc0, pc1, pc2;
    always @(posedge clk) begin
        if (!rst_a) begin
            ga <= 2'd0;
            pa <= 2'd0;
        end else begin
            ga <= ga + 2'(on_a);
            pa <= ga;
        end
        if (!rst_bc) begin
            gb  <= 2'd0;
            gc  <= 2'd0;
            pc0 <= 2'd0;
            pc1 <= 2'd0;
            pc2 <= 2'd0;
        end else begin
            gb  <= gb + 2'(on_b);
            gc  <= gc + 2'(on_c);
            pc0 <= gc;
            pc1 <= pc0;
            pc2 <= pc1;
        end
    end

    logic [1:0] cnt_a, cnt_b, cnt_c;
    assign cnt_a = pa ^ cor_a;
    assign cnt_b = gb;
    assign cnt_c = pc2 ^ cor_c;

    logic       lock_a, lock_b, lock_c, err_a, err_b, err_c;
    logic [7:0] errc_a, errc_b;
    logic [1:0] errc_c, exp_a, exp_b, exp_c;

    cnt_stream_checker #(.W(2), .LAT(LAT_A), .LOCK_CNT(LOCK), .MISS_MAX(3), .ECW(8)) u_a (
        .clk(clk), .rst_n(rst_a), .on_i(on_a), .cnt_i(cnt_a),
        .locked_o(lock_a), .err_o(err_a), .err_cnt_o(errc_a), .exp_o(exp_a));

    cnt_stream_checker #(.W(2), .LAT(LAT_B), .LOCK_CNT(LOCK), .MISS_MAX(3), .ECW(8)) u_b (
        .clk(clk), .rst_n(rst_bc), .on_i(on_b), .cnt_i(cnt_b),
        .locked_o(lock_b), .err_o(err_b), .err_cnt_o(errc_b), .exp_o(exp_b));

    cnt_stream_checker #(.W(2), .LAT(LAT_C), .LOCK_CNT(LOCK), .MISS_MAX(3), .ECW(2)) u_c (
        .clk(clk), .rst_n(rst_bc), .on_i(on_c), .cnt_i(cnt_c),
        .locked_o(lock_c), .err_o(err_c), .err_cnt_o(errc_c), .exp_o(exp_c));

    task automatic expect_ev(input int k, input int kd, input int c, input int v);
        ev_t e;
        e.inst = k;
        e.kind = kd;
        e.cyc  = c;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic mon_evt(input int k, input int kd, input int v);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].inst == k) idx = i;
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL ev_inst%0d: got unexpected kind=%0d cyc=%0d val=%0d, required no event", k, kd, cyc, v);
        end else begin
            if (sb[idx].kind != kd || sb[idx].cyc != cyc || (kd == EV_ERR && sb[idx].val != v)) begin
                bad++;
                $display("FAIL ev_inst%0d: got kind=%0d cyc=%0d val=%0d, required kind=%0d cyc=%0d val=%0d",
                         k, kd, cyc, v, sb[idx].kind, sb[idx].cyc, sb[idx].val);
            end
            sb.delete(idx);
        end
    endtask

    task automatic mon_inst(input int k, input logic l, input logic e, input int ec, input logic lp);
        if (e) mon_evt(k, EV_ERR, ec);
        if (l && !lp) mon_evt(k, EV_UP, 0);
        if (!l && lp) mon_evt(k, EV_DN, 0);
    endtask

    logic [2:0] lp = 3'b000;
    always @(negedge clk) begin
        mon_inst(0, lock_a, err_a, int'(errc_a), lp[0]);
        mon_inst(1, lock_b, err_b, int'(errc_b), lp[1]);
        mon_inst(2, lock_c, err_c, int'(errc_c), lp[2]);
        lp <= {lock_c, lock_b, lock_a};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic run_a();
        int r, n;
        rst_a = 1'b0; on_a = 1'b1; cor_a = 2'd0;
        tick(); tick();
        chk("a_rst_locked", int'(lock_a), 0);
        chk("a_rst_err", int'(err_a), 0);
        chk("a_rst_errcnt", int'(errc_a), 0);
        chk("a_rst_exp", int'(exp_a), 0);
        r = cyc;
        expect_ev(0, EV_UP, r + LAT_A + 1 + LOCK, 0);
        rst_a = 1'b1;
        repeat (LAT_A + 1 + LOCK) tick();
        chk("a_locked", int'(lock_a), 1);
        for (int i = 0; i < 50; i++) begin
            chk("a_exp_track", int'(exp_a), (cyc - r - 1) & 3);
            chk("a_errcnt_clean", int'(errc_a), 0);
            tick();
        end
        // single corruption: sample 1 driven as 2
        n = 0;
        while (pa != 2'd1 && n < 8) begin tick(); n++; end
        chk("a_find_one", int'(pa), 1);
        cor_a = 2'd3;
        expect_ev(0, EV_ERR, cyc + 1, 1);
        tick(); cor_a = 2'd0;
        repeat (3) tick();
        chk("a_single_locked", int'(lock_a), 1);
        chk("a_single_errcnt", int'(errc_a), 1);
        cor_a = 2'd2;
        expect_ev(0, EV_ERR, cyc + 1, 2);
        tick(); cor_a = 2'd0;
        repeat (3) tick();
        chk("a_second_errcnt", int'(errc_a), 2);
        // reset while locked
        rst_a = 1'b0;
        expect_ev(0, EV_DN, cyc + 1, 0);
        tick();
        chk("a_mid_rst_locked", int'(lock_a), 0);
        chk("a_mid_rst_err", int'(err_a), 0);
        chk("a_mid_rst_errcnt", int'(errc_a), 0);
        chk("a_mid_rst_exp", int'(exp_a), 0);
        chk("a_mid_rst_state", int'(u_a.r_state), int'(cts_pkg::FILL));
        r = cyc;
        rst_a = 1'b1;
        expect_ev(0, EV_UP, r + LAT_A + 1 + LOCK, 0);
        repeat (LAT_A + 1 + LOCK) tick();
        chk("a_relock_rst", int'(lock_a), 1);
        repeat (3) tick();
        // three consecutive corruptions drop lock on the third
        r = cyc;
        cor_a = 2'd2;
        expect_ev(0, EV_ERR, r + 1, 1);
        expect_ev(0, EV_ERR, r + 2, 2);
        expect_ev(0, EV_ERR, r + 3, 3);
        expect_ev(0, EV_DN, r + 3, 0);
        expect_ev(0, EV_UP, r + 8, 0);
        tick(); tick(); tick();
        cor_a = 2'd0;
        chk("a_burst_locked", int'(lock_a), 0);
        chk("a_burst_errcnt", int'(errc_a), 3);
        repeat (5) tick();
        chk("a_burst_relock", int'(lock_a), 1);
        repeat (4) tick();
    endtask

    task automatic run_bc();
        int r;
        rst_bc = 1'b0; on_b = 1'b0; on_c = 1'b0; cor_c = 2'd0;
        tick(); tick();
        r = cyc;
        expect_ev(1, EV_UP, r + LAT_B + 1 + LOCK, 0);
        expect_ev(2, EV_UP, r + LAT_C + 1 + LOCK, 0);
        rst_bc = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            on_b = 1'($urandom_range(0, 1));
            on_c = 1'($urandom_range(0, 1));
            tick();
        end
        chk("b_rand_locked", int'(lock_b), 1);
        chk("b_rand_errcnt", int'(errc_b), 0);
        chk("c_rand_locked", int'(lock_c), 1);
        chk("c_rand_errcnt", int'(errc_c), 0);
        for (int i = 0; i < 5; i++) begin
            on_c = 1'($urandom_range(0, 1));
            cor_c = 2'd1;
            expect_ev(2, EV_ERR, cyc + 1, (i < 3) ? i + 1 : 3);
            tick(); cor_c = 2'd0;
            tick(); tick();
        end
        chk("c_sat_errcnt", int'(errc_c), 3);
        chk("c_sat_locked", int'(lock_c), 1);
    endtask

    initial begin
        fork
            run_a();
            run_bc();
        join
        repeat (3) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d events still pending (first inst=%0d kind=%0d cyc=%0d), required 0",
                     sb.size(), sb[0].inst, sb[0].kind, sb[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got cycle limit 20000 reached, required completion");
        $fatal(1);
    end

endmodule
